// File: rtl/edge_detect_if.sv
// Signal bundle for the edge detector: monitored level in, rise/down strobes out.
// With EDGE_DETECT_CNT_EN defined it also carries the counter clear and the two event counters.
interface edge_detect_if;
    logic        a;
    logic        rise;
    logic        down;
`ifdef EDGE_DETECT_CNT_EN
    logic        cnt_clr;
    logic [15:0] rise_cnt;
    logic [15:0] down_cnt;

    modport master (output a, output cnt_clr, input rise, input down, input rise_cnt, input down_cnt);
    modport slave  (input a, input cnt_clr, output rise, output down, output rise_cnt, output down_cnt);
`else
    modport master (output a, input rise, input down);
    modport slave  (input a, output rise, output down);
`endif
endinterface

// File: rtl/edge_detect.sv
// Single-bit edge detector with optional input synchronizer; registered one-clock rise/down pulses.
// Define EDGE_DETECT_CNT_EN to add saturating 16-bit rise/down event counters with synchronous clear.
module edge_detect #(
    parameter int SYNC_STAGES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    edge_detect_if.slave  ed_if
);

    logic s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = ed_if.a;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= ed_if.a;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic prev_q, armed_q, rise_q, down_q;
    logic rise_d, down_d;

    // armed_q masks the first sample after reset so a high level at release is not taken as an edge
    always_comb begin
        rise_d = armed_q &  s & ~prev_q;
        down_d = armed_q & ~s &  prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            prev_q  <= s;
            armed_q <= 1'b1;
            rise_q  <= rise_d;
            down_q  <= down_d;
        end
    end

    assign ed_if.rise = rise_q;
    assign ed_if.down = down_q;

`ifdef EDGE_DETECT_CNT_EN
    logic [15:0] rise_cnt_q, rise_cnt_d;
    logic [15:0] down_cnt_q, down_cnt_d;

    // Clear beats increment; counts stick at all-ones
    always_comb begin
        rise_cnt_d = rise_cnt_q;
        down_cnt_d = down_cnt_q;
        if (ed_if.cnt_clr) begin
            rise_cnt_d = '0;
            down_cnt_d = '0;
        end else begin
            if (rise_q && (rise_cnt_q != 16'hFFFF)) rise_cnt_d = rise_cnt_q + 16'd1;
            if (down_q && (down_cnt_q != 16'hFFFF)) down_cnt_d = down_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_cnt_q <= '0;
            down_cnt_q <= '0;
        end else begin
            rise_cnt_q <= rise_cnt_d;
            down_cnt_q <= down_cnt_d;
        end
    end

    assign ed_if.rise_cnt = rise_cnt_q;
    assign ed_if.down_cnt = down_cnt_q;
`endif

endmodule

// File: tb/tb_edge_detect.sv
// Bench for edge_detect: one instance with SYNC_STAGES=0 and one with SYNC_STAGES=2 share the same input.
// Counter checks are compiled in when EDGE_DETECT_CNT_EN is defined.
module tb_edge_detect;

    logic clk;
    logic rst_n;
    logic a;
    int   n_tests;
    int   n_fail;
    int   k;
    bit   hist [0:1023];

    edge_detect_if if0 ();
    edge_detect_if if2 ();

    assign if0.a = a;
    assign if2.a = a;

`ifdef EDGE_DETECT_CNT_EN
    logic cnt_clr;
    assign if0.cnt_clr = cnt_clr;
    assign if2.cnt_clr = cnt_clr;
`endif

    edge_detect #(.SYNC_STAGES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .ed_if(if0));
    edge_detect #(.SYNC_STAGES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .ed_if(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Synchronized sample seen at edge j for a chain of d stages (chain cleared by reset)
    function automatic bit s_at(input int d, input int j);
        return (j >= d) ? hist[j-d] : 1'b0;
    endfunction

    // Drive a at the falling edge, let one rising edge sample it, then compare both DUTs to the model
    task automatic step(input bit v);
        bit er0, ed0, er2, ed2;
        @(negedge clk);
        a = v;
        @(posedge clk);
        hist[k] = v;
        #1;
        er0 = (k >= 1) &&  s_at(0, k) && !s_at(0, k-1);
        ed0 = (k >= 1) && !s_at(0, k) &&  s_at(0, k-1);
        er2 = (k >= 1) &&  s_at(2, k) && !s_at(2, k-1);
        ed2 = (k >= 1) && !s_at(2, k) &&  s_at(2, k-1);
        check("rise0", 32'(if0.rise), 32'(er0));
        check("down0", 32'(if0.down), 32'(ed0));
        check("rise2", 32'(if2.rise), 32'(er2));
        check("down2", 32'(if2.down), 32'(ed2));
        check("excl0", 32'(if0.rise & if0.down), 32'd0);
        k++;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        k     = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        k       = 0;
        a       = 1'b0;
        rst_n   = 1'b0;
`ifdef EDGE_DETECT_CNT_EN
        cnt_clr = 1'b0;
`endif
        // Reset state
        #20;
        check("rst_rise0", 32'(if0.rise), 32'd0);
        check("rst_down0", 32'(if0.down), 32'd0);
        check("rst_rise2", 32'(if2.rise), 32'd0);
        check("rst_down2", 32'(if2.down), 32'd0);
`ifdef EDGE_DETECT_CNT_EN
        check("rst_rcnt", 32'(if0.rise_cnt), 32'd0);
        check("rst_dcnt", 32'(if0.down_cnt), 32'd0);
`endif
        release_reset();

        // Hold low for 50 cycles
        for (int i = 0; i < 50; i++) begin
            step(1'b0);
            check("hold_rise0", 32'(if0.rise), 32'd0);
            check("hold_down0", 32'(if0.down), 32'd0);
        end

        // Single rise at edge N, fall at N+5
        step(1'b1);
        check("n_rise0", 32'(if0.rise), 32'd1);
        check("n_rise2", 32'(if2.rise), 32'd0);
        step(1'b1);
        check("n1_rise0", 32'(if0.rise), 32'd0);
        step(1'b1);
        check("n2_rise2", 32'(if2.rise), 32'd1);
        step(1'b1);
        check("n3_rise2", 32'(if2.rise), 32'd0);
        step(1'b1);
        step(1'b0);
        check("n5_down0", 32'(if0.down), 32'd1);
        step(1'b0);
        check("n6_down0", 32'(if0.down), 32'd0);
        step(1'b0);
        check("n7_down2", 32'(if2.down), 32'd1);
        step(1'b0);

`ifdef EDGE_DETECT_CNT_EN
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_rcnt", 32'(if0.rise_cnt), 32'd0);
        check("clr_dcnt", 32'(if0.down_cnt), 32'd0);
`endif

        // Toggle every cycle: rise and down alternate
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check("tog_rise0", 32'(if0.rise), 32'd1);
            check("tog_ndown0", 32'(if0.down), 32'd0);
            step(1'b0);
            check("tog_down0", 32'(if0.down), 32'd1);
            check("tog_nrise0", 32'(if0.rise), 32'd0);
        end
        step(1'b0);
        step(1'b0);
        step(1'b0);

`ifdef EDGE_DETECT_CNT_EN
        check("cnt_rise3", 32'(if0.rise_cnt), 32'd3);
        check("cnt_down3", 32'(if0.down_cnt), 32'd3);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("cnt_clr_r", 32'(if0.rise_cnt), 32'd0);
        check("cnt_clr_d", 32'(if0.down_cnt), 32'd0);
`endif

        // Random level per cycle against the model
        for (int i = 0; i < 50; i++) begin
            step(1'($urandom_range(0, 1)));
        end

        // Mid-pulse reset: rise must drop as soon as rst_n falls
        step(1'b0);
        step(1'b1);
        check("mid_rise0", 32'(if0.rise), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rise0", 32'(if0.rise), 32'd0);
        check("mid_rst_down0", 32'(if0.down), 32'd0);
        release_reset();

        // a already high at release: first sample gives no rise, later fall gives one down
        step(1'b1);
        check("first_rise0", 32'(if0.rise), 32'd0);
        step(1'b1);
        check("first1_rise0", 32'(if0.rise), 32'd0);
        step(1'b0);
        check("late_down0", 32'(if0.down), 32'd1);
        step(1'b0);
        check("late1_down0", 32'(if0.down), 32'd0);
        step(1'b0);
        step(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
